// File: rtl/fnd_pkg.sv
// Shared constants, types and segment helpers for the FND display controller.
package fnd_pkg;

    localparam int unsigned BCD_W    = 16;
    localparam int unsigned MAX_DISP = 9999;

    // Active-low segment codes {dp,g,f,e,d,c,b,a}, dp always off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    typedef enum logic [1:0] {
        B2B_IDLE,
        B2B_CAPTURE,
        B2B_SHIFT,
        B2B_COMMIT
    } b2b_state_e;

    // Segment bytes for the four digits; d0 is the ones digit
    typedef struct packed {
        logic [7:0] d3;
        logic [7:0] d2;
        logic [7:0] d1;
        logic [7:0] d0;
    } disp_t;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
        logic [7:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Full display image for a converted value: dashes on overflow, optional zero blanking
    function automatic disp_t render_disp(input logic [BCD_W-1:0] bcd, input logic over,
                                          input logic lzb);
        disp_t r;
        r.d0 = bcd_to_seg(bcd[3:0]);
        r.d1 = bcd_to_seg(bcd[7:4]);
        r.d2 = bcd_to_seg(bcd[11:8]);
        r.d3 = bcd_to_seg(bcd[15:12]);
        if (over) begin
            r = '{d3: SEG_DASH, d2: SEG_DASH, d1: SEG_DASH, d0: SEG_DASH};
        end else if (lzb) begin
            if (bcd[15:12] == 4'd0) r.d3 = SEG_BLANK;
            if (bcd[15:8]  == 8'd0) r.d2 = SEG_BLANK;
            if (bcd[15:4]  == 12'd0) r.d1 = SEG_BLANK;
        end
        return r;
    endfunction

endpackage

// File: rtl/fnd_controller_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one add-3/shift step per cycle.
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int unsigned SH_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    b2b_state_e       state_q, state_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SH_W-1:0]  adj_c;
    logic             last_c;

    assign last_c = (cnt_q == CNT_W'(BIN_W - 1));

    // Add-3 correction on every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        adj_c = sh_q;
        for (int i = 0; i < 4; i++) begin
            if (sh_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                adj_c[BIN_W + 4*i +: 4] = sh_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= B2B_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: capture, BIN_W shifts, one commit cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            B2B_IDLE:    if (start) state_d = B2B_CAPTURE;
            B2B_CAPTURE: state_d = B2B_SHIFT;
            B2B_SHIFT:   if (last_c) state_d = B2B_COMMIT;
            B2B_COMMIT:  state_d = B2B_IDLE;
            default:     state_d = B2B_IDLE;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        busy_d = (state_d == B2B_SHIFT) || (state_d == B2B_COMMIT);
        done_d = (state_d == B2B_COMMIT);
        case (state_q)
            B2B_IDLE: begin
                if (start) begin
                    sh_d  = {BCD_W'(0), bin};
                    cnt_d = '0;
                end
            end
            B2B_SHIFT: begin
                sh_d  = adj_c << 1;
                cnt_d = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = sh_q[SH_W-1 -: BCD_W];

endmodule

// File: rtl/fnd_controller.sv
// 4-digit common-anode FND driver: BCD conversion, one-deep pending slot, digit scan.
module fnd_controller
    import fnd_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned SCAN_HZ  = 1_000,
    parameter int unsigned BIN_W    = 14,
    parameter bit          LZB      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] count_data,
    input  logic             count_valid,
    output logic             busy,
    output logic [3:0]       fnd_com,
    output logic [7:0]       fnd_data
);

    localparam int unsigned DWELL  = (CLK_FREQ / SCAN_HZ > 0) ? CLK_FREQ / SCAN_HZ : 1;
    localparam int unsigned SCAN_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam disp_t DISP_RST = '{d3: LZB ? SEG_BLANK : SEG_0,
                                   d2: LZB ? SEG_BLANK : SEG_0,
                                   d1: LZB ? SEG_BLANK : SEG_0,
                                   d0: SEG_0};

    logic              pend_valid_q, pend_valid_d;
    logic [BIN_W-1:0]  pend_data_q, pend_data_d;
    logic              active_q, active_d;
    logic              over_q, over_d;
    disp_t             disp_q, disp_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        digit_sel_q, digit_sel_d;
    logic [3:0]        fnd_com_q, fnd_com_d;
    logic [7:0]        fnd_data_q, fnd_data_d;

    logic              start_c;
    logic [BIN_W-1:0]  start_bin_c;
    logic              eng_done;
    logic [BCD_W-1:0]  eng_bcd;

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (start_c),
        .bin   (start_bin_c),
        .busy  (busy),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    // Conversion launch, pending slot and atomic display commit
    always_comb begin
        start_c      = 1'b0;
        start_bin_c  = count_data;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        active_d     = active_q;
        over_d       = over_q;
        disp_d       = disp_q;
        if (!active_q) begin
            if (pend_valid_q) begin
                start_c      = 1'b1;
                start_bin_c  = pend_data_q;
                pend_valid_d = count_valid;
                pend_data_d  = count_data;
            end else if (count_valid) begin
                start_c = 1'b1;
            end
        end else if (count_valid) begin
            pend_valid_d = 1'b1;
            pend_data_d  = count_data;
        end
        if (start_c) begin
            active_d = 1'b1;
            over_d   = (32'(start_bin_c) > MAX_DISP);
        end else if (eng_done) begin
            active_d = 1'b0;
        end
        if (eng_done) begin
            disp_d = render_disp(eng_bcd, over_q, LZB);
        end
    end

    // Free-running digit scan; outputs follow the next digit and next display image
    always_comb begin
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        digit_sel_d = digit_sel_q;
        if (scan_cnt_q == SCAN_W'(DWELL - 1)) begin
            scan_cnt_d  = '0;
            digit_sel_d = digit_sel_q + 2'd1;
        end
        fnd_com_d = ~(4'b0001 << digit_sel_d);
        case (digit_sel_d)
            2'd0:    fnd_data_d = disp_d.d0;
            2'd1:    fnd_data_d = disp_d.d1;
            2'd2:    fnd_data_d = disp_d.d2;
            default: fnd_data_d = disp_d.d3;
        endcase
    end

    // All top-level state and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            active_q     <= 1'b0;
            over_q       <= 1'b0;
            disp_q       <= DISP_RST;
            scan_cnt_q   <= '0;
            digit_sel_q  <= 2'd0;
            fnd_com_q    <= 4'b1110;
            fnd_data_q   <= SEG_0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            active_q     <= active_d;
            over_q       <= over_d;
            disp_q       <= disp_d;
            scan_cnt_q   <= scan_cnt_d;
            digit_sel_q  <= digit_sel_d;
            fnd_com_q    <= fnd_com_d;
            fnd_data_q   <= fnd_data_d;
        end
    end

    assign fnd_com  = fnd_com_q;
    assign fnd_data = fnd_data_q;

endmodule

// File: tb/tb_fnd_controller.sv
// Randomized bench for fnd_controller against a transaction-level display model.
module tb_fnd_controller;

    localparam int unsigned CLK_FREQ = 1000;
    localparam int unsigned SCAN_HZ  = 250;
    localparam int unsigned DWELL    = CLK_FREQ / SCAN_HZ;
    localparam int unsigned BIN_W    = 14;
    localparam int          LAT      = BIN_W + 1;

    logic             clk;
    logic             reset;
    logic             count_valid;
    logic [BIN_W-1:0] count_data;
    logic             busy0, busy1;
    logic [3:0]       com0, com1;
    logic [7:0]       dat0, dat1;

    int total = 0;
    int bad   = 0;

    // Model: edges since reset release, conversion age, pending slot, shown value
    int m_edges;
    int m_conv_t;
    int m_conv_val;
    bit m_pend_v;
    int m_pend_val;
    int m_disp;

    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    fnd_controller #(
        .CLK_FREQ (CLK_FREQ), .SCAN_HZ (SCAN_HZ), .BIN_W (BIN_W), .LZB (1'b1)
    ) dut_lzb (
        .clk (clk), .reset (reset), .count_data (count_data), .count_valid (count_valid),
        .busy (busy0), .fnd_com (com0), .fnd_data (dat0)
    );

    fnd_controller #(
        .CLK_FREQ (CLK_FREQ), .SCAN_HZ (SCAN_HZ), .BIN_W (BIN_W), .LZB (1'b0)
    ) dut_nz (
        .clk (clk), .reset (reset), .count_data (count_data), .count_valid (count_valid),
        .busy (busy1), .fnd_com (com1), .fnd_data (dat1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] exp_seg(input int val, input int dig, input bit lzb);
        int p;
        p = 1;
        for (int k = 0; k < dig; k++) p = p * 10;
        if (val > 9999) return 8'hBF;
        if (lzb && dig > 0 && val < p) return 8'hFF;
        return seg_tab[(val / p) % 10];
    endfunction

    task automatic model_reset();
        m_edges    = 0;
        m_conv_t   = -1;
        m_conv_val = 0;
        m_pend_v   = 1'b0;
        m_pend_val = 0;
        m_disp     = 0;
    endtask

    // One clock edge: idle accepts (pending first), busy parks the latest strobe
    task automatic model_step(input bit v, input int d);
        m_edges++;
        if (m_conv_t < 0) begin
            if (m_pend_v) begin
                m_conv_val = m_pend_val;
                m_conv_t   = 0;
                m_pend_v   = v;
                m_pend_val = d;
            end else if (v) begin
                m_conv_val = d;
                m_conv_t   = 0;
            end
        end else begin
            if (v) begin
                m_pend_v   = 1'b1;
                m_pend_val = d;
            end
            if (m_conv_t == LAT) begin
                m_disp   = m_conv_val;
                m_conv_t = -1;
            end else begin
                m_conv_t++;
            end
        end
    endtask

    task automatic check_outputs();
        int         dig;
        logic [3:0] exp_com;
        dig     = int'((m_edges / DWELL) % 4);
        exp_com = ~(4'b0001 << dig);
        check("busy_lzb", 32'(busy0), 32'(m_conv_t >= 1));
        check("busy_nz",  32'(busy1), 32'(m_conv_t >= 1));
        check("com_lzb",  32'(com0), 32'(exp_com));
        check("com_nz",   32'(com1), 32'(exp_com));
        check("seg_lzb",  32'(dat0), 32'(exp_seg(m_disp, dig, 1'b1)));
        check("seg_nz",   32'(dat1), 32'(exp_seg(m_disp, dig, 1'b0)));
        check("onehot",   32'($countones(~com1)), 32'd1);
    endtask

    // Per-cycle reference comparison, sampled 1 time unit after the rising edge
    initial begin : monitor
        model_reset();
        forever begin
            @(posedge clk);
            if (reset) model_reset();
            else model_step(count_valid, int'(count_data));
            #1;
            check_outputs();
        end
    end

    // Caller sits at a negedge; value is sampled on the following rising edge
    task automatic strobe(input int v);
        count_valid = 1'b1;
        count_data  = BIN_W'(v);
        @(negedge clk);
        count_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : stim
        int v;
        reset       = 1'b1;
        count_valid = 1'b0;
        count_data  = '0;
        idle(3);
        reset = 1'b0;

        // Idle scan of value 0
        idle(20);

        // Single conversion
        strobe(1234);
        idle(40);

        // Back-to-back strobes while busy: last pending wins
        strobe(42);
        idle(2);
        strobe(7);
        idle(1);
        strobe(815);
        idle(60);

        // Largest displayable value, then overflow
        strobe(9999);
        idle(40);
        strobe(10000);
        idle(40);

        // Reset in the middle of a conversion
        strobe(5678);
        idle(7);
        reset = 1'b1;
        #1;
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_com",  32'(com0),  32'h0000000E);
        check("rst_seg",  32'(dat0),  32'h000000C0);
        check("rst_seg_nz", 32'(dat1), 32'h000000C0);
        idle(2);
        reset = 1'b0;
        idle(30);

        // Small value, long scan observation
        strobe(5);
        idle(1000);

        // Random traffic, including overflow values and strobes landing while busy
        for (int i = 0; i < 250; i++) begin
            idle($urandom_range(0, 20));
            case ($urandom_range(0, 3))
                0:       v = int'($urandom_range(0, 16383));
                1:       v = int'($urandom_range(0, 99));
                default: v = int'($urandom_range(0, 9999));
            endcase
            strobe(v);
        end
        idle(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
